wb_bypass_stage: RTL
====================

WB_BYPASS_STAGE -- requirements
Module: wb_bypass_stage

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 5, register-file address width.
REQ-003 Parameter NSRC, default 4, number of result sources (ALU, scratch, SP, IN port); minimum 2.
REQ-004 Parameter NRD, default 2, number of register-file read ports given bypass.
REQ-005 Parameter CNT_W, default 16, width of the retired-write counter.
REQ-006 Clock and reset: one clock `clk`, with synchronous, active-high reset `rst`.
REQ-007 clk  in  1  sole clock; all state updates on posedge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 in_valid  in  1  EX stage holds a real instruction.
REQ-010 in_write  in  1  EX instruction writes the register file.
REQ-011 in_rf_wr_sel  in  $clog2(NSRC)  result-source select.
REQ-012 in_src  in  NSRC*DATA_W  flattened sources; source k at bits [k*DATA_W +: DATA_W].
REQ-013 in_reg_addr  in  ADDR_W  destination register.
REQ-014 stall  in  1  hold WB entry; do not accept EX.
REQ-015 flush  in  1  replace the captured EX entry with a bubble.
REQ-016 rd_addr  in  NRD*ADDR_W  read addresses from the decode stage.
REQ-017 rd_rf_data  in  NRD*DATA_W  raw register-file read data.
REQ-018 out_write  out  1  register-file write enable.
REQ-019 out_reg_addr  out  ADDR_W  write address.
REQ-020 out_data  out  DATA_W  write data.
REQ-021 out_valid  out  1  WB holds a real instruction.
REQ-022 fwd_data  out  NRD*DATA_W  bypassed read data.
REQ-023 fwd_hit  out  NRD  per-port bypass taken.
REQ-024 retired_cnt  out  CNT_W  committed-write count.

Function
REQ-025 Source mux SHALL be applied before the register: captured data = in_src[in_rf_wr_sel]; if in_rf_wr_sel >= NSRC, the captured data SHALL be 0.
REQ-026 Capture rules, priority order: flush loads a bubble (valid=0, write=0, addr/data=0); else stall holds the WB entry; else the WB entry loads the EX entry.
REQ-027 Each captured entry SHALL carry a committed flag, cleared on load.
REQ-028 out_write SHALL equal wb_valid & wb_write & ~committed.
REQ-029 committed SHALL be set on the posedge after out_write=1, so a held entry writes exactly once regardless of stall length.
REQ-030 Latency SHALL be one cycle from EX capture to out_write.
REQ-031 out_valid, out_reg_addr and out_data SHALL reflect the WB entry combinationally from its registers.
REQ-032 Per port p, bypass priority SHALL be: (1) EX: in_valid & in_write & ~flush & in_reg_addr==rd_addr[p] gives the EX mux result; (2) WB: out_write & out_reg_addr==rd_addr[p] gives out_data; (3) otherwise rd_rf_data[p].
REQ-033 fwd_hit[p] SHALL be 1 for cases (1) and (2).
REQ-034 The bypass path SHALL be purely combinational.
REQ-035 retired_cnt SHALL increment by 1 on each posedge where out_write=1, and SHALL saturate at all-ones with no wrap.
REQ-036 Simultaneous stall and flush: flush wins; a held, uncommitted WB entry is replaced by the bubble only after it has written, since out_write is combinational in that cycle.
REQ-037 Reset mid-stall SHALL discard the held entry without a write after reset.

Reset
REQ-038 When rst=1 at posedge, the WB entry SHALL become a bubble: valid=0, write=0, addr=0, data=0, committed=0.
REQ-039 When rst=1 at posedge, retired_cnt SHALL become 0.
REQ-040 In the cycle following reset, out_write=0, out_valid=0, out_data=0, out_reg_addr=0 and fwd_hit=0 unless an EX hit exists.
REQ-041 rst SHALL override stall and flush.

Structure
REQ-042 A shared package SHALL hold the default widths, the rf_wr_sel encodings (SEL_ALU=0, SEL_SCR=1, SEL_SP=2, SEL_IN=3) and the packed WB entry struct.
REQ-043 One sub-module, wb_bypass_mux, SHALL implement the per-port bypass compare/select and be instantiated NRD times via generate.

Verification
REQ-044 Reset, then EX valid write, sel=0, src0=0x5A, addr=3, no stall -> next cycle out_write=1, addr=3, data=0x5A, retired_cnt=1.
REQ-045 Same entry with stall held 4 cycles -> out_write high for exactly one cycle, out_valid high all 4, retired_cnt=1.
REQ-046 flush with EX valid write addr=7 -> next cycle out_valid=0, out_write=0, no count change.
REQ-047 WB writes r3=0x11 while EX writes r3 with 0x22, rd_addr[0]=3 -> fwd_data[0]=0x22, fwd_hit[0]=1; with EX invalid -> 0x11; no match -> rd_rf_data.
REQ-048 CNT_W=4, 20 back-to-back writes -> retired_cnt stops at 0xF.
REQ-049 rst asserted during a 3-cycle stall of an uncommitted entry -> no write after reset, all outputs 0.

Source files
------------

// File: rtl/wb_bypass_stage_pkg.sv
// Shared widths, result-source encodings and WB entry flags
// for the write-back / bypass stage.
package wb_bypass_stage_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int NSRC_DEF   = 4;
    localparam int NRD_DEF    = 2;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        SEL_ALU = 2'd0,
        SEL_SCR = 2'd1,
        SEL_SP  = 2'd2,
        SEL_IN  = 2'd3
    } rf_wr_sel_e;

    // Address and data are parameter-sized, so they live beside this struct
    typedef struct packed {
        logic valid;
        logic write;
        logic committed;
    } wb_entry_t;

endpackage

// File: rtl/wb_bypass_stage_if.sv
// EX-to-WB bundle: captured instruction in, register-file write out.
// master is the pipeline side, slave is the WB stage.
interface wb_bypass_stage_if
    import wb_bypass_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NSRC   = NSRC_DEF
) ();
    localparam int SEL_W = $clog2(NSRC);

    logic                   in_valid;
    logic                   in_write;
    logic [SEL_W-1:0]       in_rf_wr_sel;
    logic [NSRC*DATA_W-1:0] in_src;
    logic [ADDR_W-1:0]      in_reg_addr;
    logic                   stall;
    logic                   flush;

    logic                   out_write;
    logic [ADDR_W-1:0]      out_reg_addr;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;

    modport master (
        output in_valid, in_write, in_rf_wr_sel,
        output in_src, in_reg_addr, stall, flush,
        input  out_write, out_reg_addr, out_data, out_valid
    );

    modport slave (
        input  in_valid, in_write, in_rf_wr_sel,
        input  in_src, in_reg_addr, stall, flush,
        output out_write, out_reg_addr, out_data, out_valid
    );
endinterface

// File: rtl/wb_bypass_mux.sv
// One read port of the bypass network: EX result first,
// then the pending WB write, then the raw register file.
module wb_bypass_mux
    import wb_bypass_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              ex_en,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_hit
);
    logic ex_hit;
    logic wb_hit;

    assign ex_hit = ex_en & (ex_addr == rd_addr);
    assign wb_hit = wb_en & (wb_addr == rd_addr) & ~ex_hit;

    always_comb begin
        fwd_data = rf_data;
        fwd_hit  = 1'b0;
        unique case (1'b1)
            ex_hit: begin
                fwd_data = ex_data;
                fwd_hit  = 1'b1;
            end
            wb_hit: begin
                fwd_data = wb_data;
                fwd_hit  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/wb_bypass_stage.sv
// Write-back register with write-once commit tracking,
// saturating retire counter and per-port operand bypass.
module wb_bypass_stage
    import wb_bypass_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NSRC   = NSRC_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_bypass_stage_if.slave      bus,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    input  logic [NRD*DATA_W-1:0] rd_rf_data,
    output logic [NRD*DATA_W-1:0] fwd_data,
    output logic [NRD-1:0]        fwd_hit,
    output logic [CNT_W-1:0]      retired_cnt
);
    localparam int SEL_W = $clog2(NSRC);

    wb_entry_t         wb;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] ex_data;
    logic              ex_fwd;
    logic              wr;

    // Unpopulated select codes read as zero
    always_comb begin
        ex_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.in_rf_wr_sel == SEL_W'(k))
                ex_data = bus.in_src[k*DATA_W +: DATA_W];
        end
    end

    assign wr     = wb.valid & wb.write & ~wb.committed;
    assign ex_fwd = bus.in_valid & bus.in_write & ~bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb          <= '0;
            wb_addr     <= '0;
            wb_data     <= '0;
            retired_cnt <= '0;
        end else begin
            if (wr && retired_cnt != '1)
                retired_cnt <= retired_cnt + CNT_W'(1);
            if (bus.flush) begin
                wb      <= '0;
                wb_addr <= '0;
                wb_data <= '0;
            end else if (bus.stall) begin
                if (wr)
                    wb.committed <= 1'b1;
            end else begin
                wb.valid     <= bus.in_valid;
                wb.write     <= bus.in_write;
                wb.committed <= 1'b0;
                wb_addr      <= bus.in_reg_addr;
                wb_data      <= ex_data;
            end
        end
    end

    assign bus.out_write    = wr;
    assign bus.out_valid    = wb.valid;
    assign bus.out_reg_addr = wb_addr;
    assign bus.out_data     = wb_data;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        wb_bypass_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_mux (
            .ex_en    (ex_fwd),
            .ex_addr  (bus.in_reg_addr),
            .ex_data  (ex_data),
            .wb_en    (wr),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
            .rf_data  (rd_rf_data[p*DATA_W +: DATA_W]),
            .fwd_data (fwd_data[p*DATA_W +: DATA_W]),
            .fwd_hit  (fwd_hit[p])
        );
    end
endmodule
